uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among three byte requesters.
// Optional ISSUE-state watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] REQ,
  input  logic [7:0] DATA_0,
  input  logic [7:0] DATA_1,
  input  logic [7:0] DATA_2,
  output logic [2:0] ACK,
  output logic [2:0] GNT,
  input  logic       TX_RDY_R,
  output logic       TX_RDY_T,
  output logic [7:0] TX_DATA_R,
  output logic       BUSY,
  output logic       TO_ERR
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] gnt_q, gnt_d;
  logic [2:0] ack_q, ack_d;
  logic [7:0] data_q, data_d;
  logic [1:0] win;
  logic       timeout_hit;

  // First requesting index found scanning ptr, ptr+1, ptr+2 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 2; k >= 0; k--) begin
      idx = 2'((int'(ptr) + k) % 3);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [1:0] ptr_after(input logic [2:0] gnt);
    case (gnt)
      3'b001:  ptr_after = 2'd1;
      3'b010:  ptr_after = 2'd2;
      default: ptr_after = 2'd0;
    endcase
  endfunction

  assign win = rr_pick(REQ, ptr_q);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             to_err_q;

  always_ff @(posedge CLK) begin
    if (RST || state_q != ISSUE) cnt_q <= '0;
    else                         cnt_q <= cnt_q + 1'b1;
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) to_err_q <= 1'b0;
    else     to_err_q <= (state_q == ISSUE) && TX_RDY_R && timeout_hit;
  end

  assign TO_ERR = to_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit = 1'b0;
  assign TO_ERR      = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack_d   = 3'b000;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (TX_RDY_R && (|REQ)) begin
          state_d = ISSUE;
          gnt_d   = 3'b001 << win;
          case (win)
            2'd1:    data_d = DATA_1;
            2'd2:    data_d = DATA_2;
            default: data_d = DATA_0;
          endcase
        end
      end
      ISSUE: begin
        if (!TX_RDY_R) begin
          state_d = WAIT_DONE;
          ack_d   = gnt_q;
          ptr_d   = ptr_after(gnt_q);
        end else if (timeout_hit) begin
          state_d = IDLE;
          gnt_d   = 3'b000;
          ptr_d   = ptr_after(gnt_q);
        end
      end
      WAIT_DONE: begin
        if (TX_RDY_R) begin
          state_d = IDLE;
          gnt_d   = 3'b000;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant, latched byte, pointer and ACK pulse are registered alongside the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q  <= 2'd0;
      gnt_q  <= 3'b000;
      ack_q  <= 3'b000;
      data_q <= 8'h00;
    end else begin
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      ack_q  <= ack_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    TX_RDY_T  = (state_q == ISSUE);
    BUSY      = (state_q != IDLE);
    GNT       = gnt_q;
    ACK       = ack_q;
    TX_DATA_R = data_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single grant, round-robin order,
// transmitter-busy hold-off, data capture at grant, mid-transfer reset, timeout.
module tb_uart_tx_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] REQ;
  logic [7:0] DATA_0, DATA_1, DATA_2;
  logic [2:0] ACK, GNT;
  logic       TX_RDY_R, TX_RDY_T, BUSY, TO_ERR;
  logic [7:0] TX_DATA_R;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .DATA_0(DATA_0), .DATA_1(DATA_1), .DATA_2(DATA_2),
    .ACK(ACK), .GNT(GNT), .TX_RDY_R(TX_RDY_R), .TX_RDY_T(TX_RDY_T),
    .TX_DATA_R(TX_DATA_R), .BUSY(BUSY), .TO_ERR(TO_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_txrdy"}, {7'd0, TX_RDY_T}, 8'h00);
    chk({tag, "_ack"},   {5'd0, ACK},      8'h00);
    chk({tag, "_gnt"},   {5'd0, GNT},      8'h00);
    chk({tag, "_busy"},  {7'd0, BUSY},     8'h00);
    chk({tag, "_toerr"}, {7'd0, TO_ERR},   8'h00);
    chk({tag, "_data"},  TX_DATA_R,        8'h00);
  endtask

  logic [7:0] exp_data [4];
  logic [2:0] exp_gnt  [4];

  initial begin
    RST = 1'b1; REQ = 3'b000; TX_RDY_R = 1'b1;
    DATA_0 = 8'h00; DATA_1 = 8'h00; DATA_2 = 8'h00;
    tick(); tick();
    chk_reset_outputs("reset");

    // Single requester: grant next cycle, ACK when UART drops ready
    RST = 1'b0; REQ = 3'b001; DATA_0 = 8'hA5;
    tick();
    chk("t1_txrdy", {7'd0, TX_RDY_T}, 8'h01);
    chk("t1_data",  TX_DATA_R,        8'hA5);
    chk("t1_gnt",   {5'd0, GNT},      8'h01);
    chk("t1_noack", {5'd0, ACK},      8'h00);
    TX_RDY_R = 1'b0;
    tick();
    chk("t1_ack",    {5'd0, ACK},      8'h01);
    chk("t1_txrdy0", {7'd0, TX_RDY_T}, 8'h00);
    REQ = 3'b000;
    tick();
    chk("t1_ackpulse", {5'd0, ACK},  8'h00);
    chk("t1_busywait", {7'd0, BUSY}, 8'h01);
    TX_RDY_R = 1'b1;
    tick();
    chk("t1_gntclr", {5'd0, GNT},  8'h00);
    chk("t1_idle",   {7'd0, BUSY}, 8'h00);
    chk("t1_hold",   TX_DATA_R,    8'hA5);

    // Round-robin with all three requesting continuously
    RST = 1'b1; tick(); RST = 1'b0;
    exp_data = '{8'h10, 8'h20, 8'h30, 8'h10};
    exp_gnt  = '{3'b001, 3'b010, 3'b100, 3'b001};
    REQ = 3'b111; DATA_0 = 8'h10; DATA_1 = 8'h20; DATA_2 = 8'h30;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr%0d_data", i), TX_DATA_R, exp_data[i]);
      chk($sformatf("rr%0d_gnt", i), {5'd0, GNT}, {5'd0, exp_gnt[i]});
      TX_RDY_R = 1'b0;
      tick();
      chk($sformatf("rr%0d_ack", i), {5'd0, ACK}, {5'd0, exp_gnt[i]});
      TX_RDY_R = 1'b1;
      tick();
      chk($sformatf("rr%0d_ackoff", i), {5'd0, ACK}, 8'h00);
      chk($sformatf("rr%0d_idle", i), {7'd0, BUSY}, 8'h00);
    end
    REQ = 3'b000;

    // Transmitter not ready: no grant until it is
    TX_RDY_R = 1'b0; REQ = 3'b010;
    tick();
    chk("t3_nogrant_a", {5'd0, GNT}, 8'h00);
    tick();
    chk("t3_nogrant_b", {7'd0, TX_RDY_T}, 8'h00);
    TX_RDY_R = 1'b1;
    tick();
    chk("t3_gnt",  {5'd0, GNT},      8'h02);
    chk("t3_tx",   {7'd0, TX_RDY_T}, 8'h01);
    chk("t3_data", TX_DATA_R,        8'h20);
    TX_RDY_R = 1'b0;
    tick();
    chk("t3_ack", {5'd0, ACK}, 8'h02);
    REQ = 3'b000; TX_RDY_R = 1'b1;
    tick();

    // Data captured at grant; later DATA change and REQ drop are ignored
    REQ = 3'b100; DATA_2 = 8'h3C;
    tick();
    chk("t4_gnt", {5'd0, GNT}, 8'h04);
    DATA_2 = 8'hFF; REQ = 3'b000;
    tick();
    chk("t4_data", TX_DATA_R,        8'h3C);
    chk("t4_tx",   {7'd0, TX_RDY_T}, 8'h01);
    TX_RDY_R = 1'b0;
    tick();
    chk("t4_ack",   {5'd0, ACK}, 8'h04);
    chk("t4_data2", TX_DATA_R,   8'h3C);
    TX_RDY_R = 1'b1;
    tick();

    // Reset during WAIT_DONE; pointer returns to requester 0
    REQ = 3'b001; DATA_0 = 8'h55;
    tick();
    TX_RDY_R = 1'b0;
    tick();
    REQ = 3'b000;
    tick();
    RST = 1'b1;
    tick();
    chk_reset_outputs("t5_rst");
    RST = 1'b0; TX_RDY_R = 1'b1; REQ = 3'b011; DATA_0 = 8'h11; DATA_1 = 8'h22;
    tick();
    chk("t5_gnt",  {5'd0, GNT}, 8'h01);
    chk("t5_data", TX_DATA_R,   8'h11);
    // Reset coinciding with UART accept: reset wins, no ACK
    RST = 1'b1; TX_RDY_R = 1'b0;
    tick();
    chk("t5b_ack",  {5'd0, ACK},  8'h00);
    chk("t5b_busy", {7'd0, BUSY}, 8'h00);
    chk("t5b_gnt",  {5'd0, GNT},  8'h00);
    RST = 1'b0; REQ = 3'b000; TX_RDY_R = 1'b1;
    tick();

    // UART never accepts
    REQ = 3'b001; DATA_0 = 8'h77;
    tick();
    REQ = 3'b000;
`ifdef UART_ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    chk("to_pre_tx",  {7'd0, TX_RDY_T}, 8'h01);
    chk("to_pre_err", {7'd0, TO_ERR},   8'h00);
    tick();
    chk("to_err",  {7'd0, TO_ERR},   8'h01);
    chk("to_tx",   {7'd0, TX_RDY_T}, 8'h00);
    chk("to_ack",  {5'd0, ACK},      8'h00);
    chk("to_busy", {7'd0, BUSY},     8'h00);
    chk("to_gnt",  {5'd0, GNT},      8'h00);
    tick();
    chk("to_pulse", {7'd0, TO_ERR}, 8'h00);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("nto_tx",  {7'd0, TX_RDY_T}, 8'h01);
    chk("nto_err", {7'd0, TO_ERR},   8'h00);
    TX_RDY_R = 1'b0;
    tick();
    chk("nto_ack", {5'd0, ACK}, 8'h01);
    TX_RDY_R = 1'b1;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
